// File: rtl/pipe_mul_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_mul_if : operand/product valid-ready bundle for pipe_mul       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface pipe_mul_if #(
  parameter int WA = 4,
  parameter int WB = 4
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WA-1:0]      a;
  logic [WB-1:0]      b;
  logic               out_valid;
  logic               out_ready;
  logic [WA+WB-1:0]   mul;

  modport master (
    output in_valid, in_signed, a, b, out_ready,
    input  in_ready, out_valid, mul
  );

  modport slave (
    input  in_valid, in_signed, a, b, out_ready,
    output in_ready, out_valid, mul
  );
endinterface
`default_nettype wire

// File: rtl/pipe_mul.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_mul : STAGES-deep pipelined signed/unsigned multiplier         |
// | Optional accumulator enabled by macro PIPE_MUL_ACC_EN. Rev 1.0      |
// +--------------------------------------------------------------------+
module pipe_mul #(
  parameter int WA     = 4,
  parameter int WB     = 4,
  parameter int STAGES = 2,
  parameter int ACC_G  = 4
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  pipe_mul_if.slave                      bus
`ifdef PIPE_MUL_ACC_EN
  ,
  input  wire logic                      acc_clr,
  output logic [WA+WB+ACC_G-1:0]         acc
`endif
);

  localparam int WP   = WA + WB;
  localparam int LAST = STAGES - 1;

  logic              adv;
  logic [WP-1:0]     a_ext;
  logic [WP-1:0]     b_ext;
  logic [WP-1:0]     prod;
  logic [STAGES-1:0] vld;
  logic [WP-1:0]     dat [STAGES];

  // Guard bits only matter with the accumulator; nothing to build otherwise.
  if (ACC_G < 0) begin : g_acc_g_negative
  end

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Extending both operands to the full product width makes the low WP bits
  // of the product exact for either mode.
  assign a_ext = bus.in_signed ? {{WB{bus.a[WA-1]}}, bus.a} : {{WB{1'b0}}, bus.a};
  assign b_ext = bus.in_signed ? {{WA{bus.b[WB-1]}}, bus.b} : {{WA{1'b0}}, bus.b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        vld[i] <= 1'b0;
        dat[i] <= '0;
      end
    end else if (adv) begin
      vld[0] <= bus.in_valid;
      dat[0] <= prod;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign bus.out_valid = vld[LAST];
  assign bus.mul       = dat[LAST];

`ifdef PIPE_MUL_ACC_EN
  localparam int AW = WP + ACC_G;

  logic [STAGES-1:0] sgn;
  logic [AW-1:0]     mul_ext;
  logic [AW-1:0]     acc_q;
  logic              xfer;

  // The mode flag rides alongside each product so the accumulator knows how
  // to extend it when it leaves the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn <= '0;
    end else if (adv) begin
      sgn[0] <= bus.in_signed;
      for (int i = 1; i < STAGES; i++) begin
        sgn[i] <= sgn[i-1];
      end
    end
  end

  assign xfer    = bus.out_valid && bus.out_ready;
  assign mul_ext = sgn[LAST] ? {{ACC_G{bus.mul[WP-1]}}, bus.mul}
                             : {{ACC_G{1'b0}}, bus.mul};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (xfer) begin
      acc_q <= (acc_clr ? '0 : acc_q) + mul_ext;
    end else if (acc_clr) begin
      acc_q <= '0;
    end
  end

  assign acc = acc_q;
`endif

endmodule
`default_nettype wire
